// File: rtl/fmac_pkg.sv
// Shared types and constants for the fake-MAC frame generator.
package fmac_pkg;

  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned DEF_TYPE_W = 4;
  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned LFSR_W     = 8;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ANN,
    ST_SIG,
    ST_PLD,
    ST_GAP,
    ST_DONE
  } fmac_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fmac_pld_gen.sv
// Payload beat generator: pattern source, beat counter and valid/ready holding.
module fmac_pld_gen
  import fmac_pkg::*;
#(
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned PATTERN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pld_load,
  input  logic              pld_start,
  input  logic [DATA_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              pld_rdy,
  output logic [DATA_W-1:0] pld_data,
  output logic              pld_vld,
  output logic              pld_last,
  output logic              last_xfer_c
);

  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] pat_q, pat_d, pat_nxt, seed;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              xfer;

  // Next pattern value; pat_q always holds the byte for the next beat to present
  always_comb begin
    if (PATTERN != 0) begin
      pat_nxt = DATA_W'(lfsr_step(pat_q[LFSR_W-1:0]));
      seed    = DATA_W'(LFSR_SEED);
    end else begin
      pat_nxt = pat_q + DATA_W'(1);
      seed    = base;
    end
  end

  always_comb begin
    beat_d      = beat_q;
    pat_d       = pat_q;
    data_d      = data_q;
    vld_d       = vld_q;
    last_d      = last_q;
    xfer        = vld_q & pld_rdy;
    last_xfer_c = xfer & last_q;

    if (pld_load) begin
      pat_d  = seed;
      beat_d = '0;
      vld_d  = 1'b0;
      last_d = 1'b0;
    end else if (pld_start) begin
      vld_d  = 1'b1;
      data_d = pat_q;
      pat_d  = pat_nxt;
      last_d = (len == LEN_W'(1));
      beat_d = LEN_W'(1);
    end else if (xfer) begin
      if (last_q) begin
        vld_d  = 1'b0;
        last_d = 1'b0;
        data_d = '0;
      end else begin
        data_d = pat_q;
        pat_d  = pat_nxt;
        last_d = (beat_q == len - LEN_W'(1));
        beat_d = beat_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      pat_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      pat_q  <= pat_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign pld_data = data_q;
  assign pld_vld  = vld_q;
  assign pld_last = last_q;

endmodule

// File: rtl/fmac_frame_gen.sv
// Fake-MAC traffic source: frame sequencing FSM and timers around the payload generator.
module fmac_frame_gen
  import fmac_pkg::*;
#(
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned TYPE_W      = DEF_TYPE_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned START_DELAY = 1200,
  parameter int unsigned GAP         = 1200,
  parameter int unsigned NUM_FRAMES  = 1,
  parameter int unsigned PATTERN     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [TYPE_W-1:0] cfg_type,
  input  logic              tx_busy,
  output logic              new_frame,
  output logic              frame_vld,
  output logic [LEN_W-1:0]  frame_len,
  output logic [TYPE_W-1:0] frame_type,
  output logic [DATA_W-1:0] pld_data,
  output logic              pld_vld,
  input  logic              pld_rdy,
  output logic              pld_last,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              done
);

  // Timer terminal values; a zero delay or gap expires on the first cycle
  localparam logic [CNT_W-1:0] DELAY_LAST = (START_DELAY == 0) ? '0 : CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = (GAP == 0) ? '0 : CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(NUM_FRAMES);

  fmac_state_e       state_q, state_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  logic [TYPE_W-1:0] frame_type_q, frame_type_d;
  logic              new_frame_q, new_frame_d;
  logic              frame_vld_q, frame_vld_d;
  logic              done_q, done_d;

  logic              tmr_exp_c;
  logic              launch_c;
  logic              close_c;
  logic              pld_load_c;
  logic              pld_start_c;
  logic              last_xfer_c;

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    frame_cnt_d  = frame_cnt_q;
    run_cnt_d    = run_cnt_q;
    frame_len_d  = frame_len_q;
    frame_type_d = frame_type_q;
    new_frame_d  = 1'b0;
    frame_vld_d  = 1'b0;
    done_d       = done_q;
    launch_c     = 1'b0;
    close_c      = 1'b0;
    pld_load_c   = 1'b0;
    pld_start_c  = 1'b0;
    tmr_exp_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmr_d     = '0;
        run_cnt_d = '0;
        done_d    = 1'b0;
        if (en) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_exp_c = (tmr_q >= DELAY_LAST);
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tmr_exp_c) begin
          launch_c = !tx_busy;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_ANN: begin
        state_d     = ST_SIG;
        frame_vld_d = 1'b1;
        pld_load_c  = 1'b1;
      end
      ST_SIG: begin
        if (frame_len_q == '0) begin
          close_c = 1'b1;
        end else begin
          state_d     = ST_PLD;
          pld_start_c = 1'b1;
        end
      end
      ST_PLD: begin
        close_c = last_xfer_c;
      end
      ST_GAP: begin
        tmr_exp_c = (tmr_q >= GAP_LAST);
        if (!tmr_exp_c) begin
          tmr_d = tmr_q + CNT_W'(1);
        end else if (NUM_FRAMES != 0 && run_cnt_q == RUN_TARGET) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!en) begin
          state_d = ST_IDLE;
        end else begin
          launch_c = !tx_busy;
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame announce: latch descriptor alongside the new_frame pulse
    if (launch_c) begin
      state_d      = ST_ANN;
      new_frame_d  = 1'b1;
      frame_len_d  = cfg_len;
      frame_type_d = cfg_type;
    end

    // Frame close: count it and start the inter-frame gap
    if (close_c) begin
      state_d     = ST_GAP;
      tmr_d       = '0;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      run_cnt_d   = run_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      frame_cnt_q  <= '0;
      run_cnt_q    <= '0;
      frame_len_q  <= '0;
      frame_type_q <= '0;
      new_frame_q  <= 1'b0;
      frame_vld_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      frame_cnt_q  <= frame_cnt_d;
      run_cnt_q    <= run_cnt_d;
      frame_len_q  <= frame_len_d;
      frame_type_q <= frame_type_d;
      new_frame_q  <= new_frame_d;
      frame_vld_q  <= frame_vld_d;
      done_q       <= done_d;
    end
  end

  fmac_pld_gen #(
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W),
    .PATTERN(PATTERN)
  ) u_pld_gen (
    .clk        (clk),
    .rst        (rst),
    .pld_load   (pld_load_c),
    .pld_start  (pld_start_c),
    .base       (DATA_W'(frame_cnt_q)),
    .len        (frame_len_q),
    .pld_rdy    (pld_rdy),
    .pld_data   (pld_data),
    .pld_vld    (pld_vld),
    .pld_last   (pld_last),
    .last_xfer_c(last_xfer_c)
  );

  assign new_frame  = new_frame_q;
  assign frame_vld  = frame_vld_q;
  assign frame_len  = frame_len_q;
  assign frame_type = frame_type_q;
  assign frame_cnt  = frame_cnt_q;
  assign done       = done_q;

endmodule
